ssd_sequence_ctrl: RTL and testbench

Programmable serial-pattern search controller. It arms a PAT_W-bit sequence matcher on command, feeds it one serial bit per clock, bounds the search with a bit-count window, and reports hit or timeout with a saturating hit counter. It sits between the host control logic and the serial input stream. It replaces the fixed-pattern, never-clearing detector with a sequenced, re-armable one.

---
 rtl/ssd_sequence_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_ssd_sequence_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_sequence_ctrl.sv
// ssd_sequence_ctrl
//   Re-armable serial pattern search controller. On an accepted start it
//   latches a PAT_W-bit target pattern and a search window, then shifts in
//   one serial bit per SEARCH cycle. It reports a hit or a timeout, and
//   keeps a saturating count of hits since the last accepted start.
//
//   Compile-time option:
//     SSD_REARM_EN  when defined, HIT returns to SEARCH with fill and window
//                   counts cleared, so searching continues until abort or
//                   timeout. When undefined, HIT returns to IDLE, so each
//                   start produces at most one match.
//
// Ports
//   clock      rising-edge system clock
//   reset      asynchronous, active-low reset
//   start      arm request (honoured only in IDLE, and only without abort)
//   abort      cancel request (honoured in any non-IDLE state)
//   pat        target pattern, oldest bit = MSB, latched on accepted start
//   window     max bits searched per arm (0 = unlimited), latched on start
//   in         serial data bit, sampled every SEARCH cycle
//   busy       state is not IDLE
//   hit        one-cycle pulse per match (the HIT state)
//   found      sticky: at least one match since last accepted start
//   timeout    sticky: window expired without a match since last start
//   hit_count  saturating match count since last accepted start

module ssd_sequence_ctrl #(
  parameter int PAT_W = 4,
  parameter int WIN_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pat,
  input  logic [WIN_W-1:0] window,
  input  logic             in,
  output logic             busy,
  output logic             hit,
  output logic             found,
  output logic             timeout,
  output logic [CNT_W-1:0] hit_count
);

  // The fill count only needs to reach PAT_W and then saturate.
  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    HIT    = 2'd2,
    TOUT   = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  logic [PAT_W-1:0]  pat_q;
  logic [PAT_W-1:0]  pat_nx;
  logic [WIN_W-1:0]  win_q;
  logic [WIN_W-1:0]  win_nx;
  logic [PAT_W-1:0]  sr;
  logic [PAT_W-1:0]  sr_nx;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_nx;
  logic [WIN_W-1:0]  wcnt;
  logic [WIN_W-1:0]  wcnt_nx;
  logic              found_nx;
  logic              timeout_nx;
  logic [CNT_W-1:0]  count_nx;

  logic [PAT_W-1:0]  sr_shift;
  logic [FILL_W-1:0] fill_inc;
  logic [WIN_W-1:0]  wcnt_inc;
  logic              match;
  logic              win_done;

  // Values the search registers take if the current bit is consumed.
  // A match needs a full shift register of bits gathered since the last
  // (re)arm, which is what makes matching non-overlapping after a hit.
  assign sr_shift = {sr[PAT_W-2:0], in};
  assign fill_inc = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
  assign wcnt_inc = wcnt + WIN_W'(1);
  assign match    = (fill_inc == FILL_FULL) && (sr_shift == pat_q);
  assign win_done = (win_q != '0) && (wcnt_inc == win_q);

  assign busy = (state != IDLE);
  assign hit  = (state == HIT);

  always_comb begin
    state_nx   = state;
    pat_nx     = pat_q;
    win_nx     = win_q;
    sr_nx      = sr;
    fill_nx    = fill;
    wcnt_nx    = wcnt;
    found_nx   = found;
    timeout_nx = timeout;
    count_nx   = hit_count;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          pat_nx     = pat;
          win_nx     = window;
          sr_nx      = '0;
          fill_nx    = '0;
          wcnt_nx    = '0;
          found_nx   = 1'b0;
          timeout_nx = 1'b0;
          count_nx   = '0;
          state_nx   = SEARCH;
        end
      end

      SEARCH: begin
        if (abort) begin
          state_nx = IDLE;
        end else begin
          sr_nx   = sr_shift;
          fill_nx = fill_inc;
          wcnt_nx = wcnt_inc;
          // A match on the final window bit wins over the timeout.
          if (match) begin
            state_nx = HIT;
          end else if (win_done) begin
            state_nx = TOUT;
          end
        end
      end

      HIT: begin
        // The hit is booked even when abort arrives in this cycle.
        found_nx = 1'b1;
        if (hit_count != '1) begin
          count_nx = hit_count + CNT_W'(1);
        end
        if (abort) begin
          state_nx = IDLE;
        end else begin
`ifdef SSD_REARM_EN
          fill_nx  = '0;
          wcnt_nx  = '0;
          state_nx = SEARCH;
`else
          state_nx = IDLE;
`endif
        end
      end

      TOUT: begin
        timeout_nx = 1'b1;
        state_nx   = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pat_q     <= '0;
      win_q     <= '0;
      sr        <= '0;
      fill      <= '0;
      wcnt      <= '0;
      found     <= 1'b0;
      timeout   <= 1'b0;
      hit_count <= '0;
    end else begin
      state     <= state_nx;
      pat_q     <= pat_nx;
      win_q     <= win_nx;
      sr        <= sr_nx;
      fill      <= fill_nx;
      wcnt      <= wcnt_nx;
      found     <= found_nx;
      timeout   <= timeout_nx;
      hit_count <= count_nx;
    end
  end

endmodule

// File: tb/tb_ssd_sequence_ctrl.sv
// tb_ssd_sequence_ctrl
//   Scoreboard bench for ssd_sequence_ctrl. Each arm session is first run
//   through a reference model that walks the bit stream with a queue of
//   recent bits. The model pushes the expected hit pulses and the expected
//   end-of-session state into a queue. A monitor on the falling clock edge
//   pops and compares whenever the DUT shows a hit pulse or busy drops.
//   Works with and without SSD_REARM_EN.

module tb_ssd_sequence_ctrl;

  localparam int PAT_W   = 4;
  localparam int WIN_W   = 8;
  localparam int CNT_W   = 2;
  localparam int MAX_CNT = (1 << CNT_W) - 1;
`ifdef SSD_REARM_EN
  localparam bit REARM = 1'b1;
`else
  localparam bit REARM = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [PAT_W-1:0] pat = '0;
  logic [WIN_W-1:0] window = '0;
  logic             in = 1'b0;
  logic             busy;
  logic             hit;
  logic             found;
  logic             timeout;
  logic [CNT_W-1:0] hit_count;

  ssd_sequence_ctrl #(
    .PAT_W(PAT_W),
    .WIN_W(WIN_W),
    .CNT_W(CNT_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .pat      (pat),
    .window   (window),
    .in       (in),
    .busy     (busy),
    .hit      (hit),
    .found    (found),
    .timeout  (timeout),
    .hit_count(hit_count)
  );

  always #5 clock = ~clock;

  // Index of the most recent rising edge.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit is_end;
    int cycle;
    bit found;
    bit tout;
    int cnt;
  } exp_t;

  exp_t sb_q[$];
  bit   stream_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_value(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic check_output(input string name, input logic b, input logic h,
                              input logic f, input logic t, input int c);
    check_value({name, "_busy"}, busy, b);
    check_value({name, "_hit"}, hit, h);
    check_value({name, "_found"}, found, f);
    check_value({name, "_timeout"}, timeout, t);
    check_value({name, "_hit_count"}, hit_count, c);
  endtask

  // Monitor: a hit pulse or a busy fall consumes one expected event.
  logic prev_busy = 1'b0;
  exp_t mon_e;
  always @(negedge clock) begin
    if (!reset) begin
      prev_busy = 1'b0;
    end else begin
      if (hit) begin
        check_value("hit_expected", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          check_value("hit_kind", mon_e.is_end, 0);
          check_value("hit_edge", cyc, mon_e.cycle);
          check_value("hit_found", found, mon_e.found);
          check_value("hit_count_at_pulse", hit_count, mon_e.cnt);
        end
      end
      if (prev_busy && !busy) begin
        check_value("end_expected", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          check_value("end_kind", mon_e.is_end, 1);
          check_value("end_edge", cyc, mon_e.cycle);
          check_value("end_found", found, mon_e.found);
          check_value("end_timeout", timeout, mon_e.tout);
          check_value("end_hit_count", hit_count, mon_e.cnt);
        end
      end
      prev_busy = busy;
    end
  end

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) stream_q.push_back(v[i]);
  endtask

  // Runs one arm session. Called one time unit after a rising edge.
  // Edge 0 accepts start; stream bit k-1 is presented for edge k.
  task automatic apply_stimulus(input logic [PAT_W-1:0] p, input logic [WIN_W-1:0] w,
                                input int len, input int abort_at);
    int k;
    int e0;
    int end_k;
    int wc;
    int phase_end;
    int cnt;
    bit f;
    bit t;
    bit done;
    bit bits_q[$];
    logic [PAT_W-1:0] v;

    while (stream_q.size() < len) stream_q.push_back(1'($urandom_range(0, 1)));
    if (abort_at > len) abort_at = len;

    // Reference model: list the events this session must produce.
    e0 = cyc + 1;
    k = 0; f = 0; t = 0; cnt = 0; done = 0;
    while (!done) begin
      bits_q.delete();
      wc = 0;
      phase_end = 0;
      while (phase_end == 0) begin
        k++;
        if (k == abort_at) begin
          phase_end = 3;
        end else begin
          bits_q.push_back(stream_q[k-1]);
          if (bits_q.size() > PAT_W) void'(bits_q.pop_front());
          wc++;
          v = '0;
          foreach (bits_q[i]) v = {v[PAT_W-2:0], bits_q[i]};
          if (bits_q.size() == PAT_W && v == p) phase_end = 1;
          else if (w != 0 && wc == int'(w)) phase_end = 2;
        end
      end
      if (phase_end == 1) begin
        sb_q.push_back('{1'b0, e0 + k, f, t, cnt});
        k++;  // bit presented during the hit cycle is dropped
        f = 1;
        if (cnt < MAX_CNT) cnt++;
        if (k == abort_at || !REARM) done = 1;
      end else if (phase_end == 2) begin
        k++;
        t = 1;
        done = 1;
      end else begin
        done = 1;
      end
    end
    sb_q.push_back('{1'b1, e0 + k, f, t, cnt});
    end_k = k;

    // Drive: stray starts and pat/window changes while busy must be ignored.
    start  = 1'b1;
    abort  = 1'b0;
    pat    = p;
    window = w;
    in     = 1'($urandom_range(0, 1));
    @(posedge clock); #1;
    for (int j = 1; j <= end_k; j++) begin
      start  = ($urandom_range(0, 3) == 0);
      pat    = PAT_W'($urandom);
      window = WIN_W'($urandom);
      abort  = (j == abort_at);
      in     = stream_q[j-1];
      @(posedge clock); #1;
    end
    start = 1'b0;
    abort = 1'b0;
    @(posedge clock); #1;
    stream_q.delete();
  endtask

  task automatic reset_mid_search();
    start  = 1'b1;
    abort  = 1'b0;
    pat    = 4'b0110;
    window = '0;
    in     = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
    end
    check_value("busy_before_reset", busy, 1);
    #2 reset = 1'b0;
    #1 check_output("mid_search_reset", 0, 0, 0, 0, 0);
    sb_q.delete();
    @(negedge clock);
    #2 reset = 1'b1;
    @(posedge clock); #1;
  endtask

  initial begin
    logic [PAT_W-1:0] rp;
    logic [WIN_W-1:0] rw;
    int               ab;

    #2 reset = 1'b0;
    #1 check_output("reset_state", 0, 0, 0, 0, 0);
    @(negedge clock);
    #2 reset = 1'b1;
    @(posedge clock); #1;

    // start together with abort is not accepted
    start = 1'b1;
    abort = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    abort = 1'b0;
    check_value("start_with_abort_ignored", busy, 0);
    @(posedge clock); #1;

    // match with unlimited window
    push_bits(32'b10110, 5);
    apply_stimulus(4'b0110, 8'd0, 12, 12);

    // timeout with in held high
    for (int i = 0; i < 12; i++) stream_q.push_back(1'b1);
    apply_stimulus(4'b0110, 8'd6, 12, 12);

    // match on the last window bit beats timeout
    push_bits(32'b0110, 4);
    apply_stimulus(4'b0110, 8'd4, 8, 8);

    // two patterns separated by the dropped bit
    push_bits(32'b0110, 4);
    push_bits(32'b1, 1);
    push_bits(32'b0110, 4);
    apply_stimulus(4'b0110, 8'd0, 14, 14);

    // abort after two bits
    push_bits(32'b01, 2);
    apply_stimulus(4'b0110, 8'd0, 10, 3);

    // five back-to-back matches saturate the counter
    for (int i = 0; i < 5; i++) begin
      push_bits(32'b0110, 4);
      push_bits(32'b0, 1);
    end
    apply_stimulus(4'b0110, 8'd0, 30, 30);

    reset_mid_search();
    check_output("after_reset_release", 0, 0, 0, 0, 0);

    // randomized sessions
    for (int s = 0; s < 40; s++) begin
      rp = PAT_W'($urandom);
      rw = ($urandom_range(0, 2) == 0) ? '0 : WIN_W'($urandom_range(1, 20));
      ab = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 40) : 40;
      while (stream_q.size() < 40) begin
        if ($urandom_range(0, 2) == 0) push_bits(32'(rp), PAT_W);
        else stream_q.push_back(1'($urandom_range(0, 1)));
      end
      apply_stimulus(rp, rw, 40, ab);
    end

    repeat (3) begin
      @(posedge clock); #1;
    end
    check_value("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
